// File: rtl/hsram_io.sv
// High-score RAM bridge: 64x8 game RAM loaded/saved through data_io via a verified shadow copy.
// Define HSRAM_CHECKSUM_EN to enable the checksum byte at address 64 on load and upload.
module hsram_io #(
  parameter logic [7:0] INDEX = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_upload,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [7:0]  ioctl_din,
  input  logic [5:0]  cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dout,
  output logic        cpu_hold,
  output logic        load_ok,
  output logic        load_err
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, COMMIT, UPLOAD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        rst_n;
  logic        dl_q, ul_q, sel_q, sel_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        load_ok_q, load_ok_d, load_err_q, load_err_d;
  logic [7:0]  din_q, din_d, cpu_dout_q;
  logic [7:0]  main_mem   [64];
  logic [7:0]  shadow_mem [64];

  logic        dl_rise, dl_fall, ul_rise, ul_fall, idx_match;
  logic [5:0]  addr_lo;
  logic        addr_in, addr_chk, shadow_we, pass;
  logic [7:0]  upload_chk;

  // Reset asserts immediately but is released only after two clean clock edges.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;
  assign ul_rise   = ioctl_upload & ~ul_q;
  assign ul_fall   = ~ioctl_upload & ul_q;
  assign idx_match = (ioctl_index == INDEX);
  assign sel_d     = (dl_rise | ul_rise) ? idx_match : sel_q;
  assign addr_lo   = ioctl_addr[5:0];
  assign addr_in   = (ioctl_addr < 25'd64);
  assign addr_chk  = (ioctl_addr == 25'd64);
  assign shadow_we = (state_q == LOAD) && sel_q && ioctl_wr && addr_in;

`ifdef HSRAM_CHECKSUM_EN
  logic [7:0]  chk_q, chk_d, sum_q, sum_d, acc_q, acc_d, verify_sum;
  logic [63:0] seen_q, seen_d;
  assign verify_sum = sum_q + shadow_mem[cnt_q];
  assign pass       = ((verify_sum + chk_q) == 8'h00);
  assign upload_chk = 8'h00 - acc_q;
`else
  assign pass       = 1'b1;
  assign upload_chk = 8'h00;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_ok_d  = 1'b0;
    load_err_d = 1'b0;
    din_d      = 8'h00;
`ifdef HSRAM_CHECKSUM_EN
    chk_d  = chk_q;
    sum_d  = sum_q;
    acc_d  = acc_q;
    seen_d = seen_q;
`endif
    case (state_q)
      IDLE: begin
        if (dl_rise && idx_match) begin
          state_d = LOAD;
`ifdef HSRAM_CHECKSUM_EN
          chk_d = 8'h00;
`endif
        end else if (ul_rise && idx_match) begin
          state_d = UPLOAD;
`ifdef HSRAM_CHECKSUM_EN
          acc_d  = 8'h00;
          seen_d = '0;
`endif
        end
      end
      LOAD: begin
`ifdef HSRAM_CHECKSUM_EN
        if (sel_q && ioctl_wr && addr_chk) chk_d = ioctl_dout;
        if (dl_fall) sum_d = 8'h00;
`endif
        if (dl_fall) begin
          state_d = VERIFY;
          cnt_d   = 6'd0;
        end
      end
      VERIFY: begin
        cnt_d = cnt_q + 6'd1;
`ifdef HSRAM_CHECKSUM_EN
        sum_d = verify_sum;
`endif
        if (cnt_q == 6'd63) begin
          state_d    = pass ? COMMIT : IDLE;
          load_err_d = ~pass;
        end
      end
      COMMIT: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d   = IDLE;
          load_ok_d = 1'b1;
        end
      end
      UPLOAD: begin
        if (sel_q && addr_in) begin
          din_d = main_mem[addr_lo];
`ifdef HSRAM_CHECKSUM_EN
          // Each address contributes once, however long the host dwells on it.
          if (!seen_q[addr_lo]) begin
            acc_d           = acc_q + main_mem[addr_lo];
            seen_d[addr_lo] = 1'b1;
          end
`endif
        end else if (sel_q && addr_chk) begin
          din_d = upload_chk;
        end
        if (ul_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      ul_q       <= 1'b0;
      sel_q      <= 1'b0;
      cnt_q      <= 6'd0;
      load_ok_q  <= 1'b0;
      load_err_q <= 1'b0;
      din_q      <= 8'h00;
      cpu_dout_q <= 8'h00;
`ifdef HSRAM_CHECKSUM_EN
      chk_q  <= 8'h00;
      sum_q  <= 8'h00;
      acc_q  <= 8'h00;
      seen_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dl_q       <= ioctl_download;
      ul_q       <= ioctl_upload;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      load_ok_q  <= load_ok_d;
      load_err_q <= load_err_d;
      din_q      <= din_d;
      cpu_dout_q <= main_mem[cpu_addr];
`ifdef HSRAM_CHECKSUM_EN
      chk_q  <= chk_d;
      sum_q  <= sum_d;
      acc_q  <= acc_d;
      seen_q <= seen_d;
`endif
    end
  end

  // RAM contents survive reset; the commit copy owns the main write port while it runs.
  always_ff @(posedge clk_sys) begin
    if (shadow_we) shadow_mem[addr_lo] <= ioctl_dout;
    if (state_q == COMMIT) main_mem[cnt_q] <= shadow_mem[cnt_q];
    else if (cpu_we)       main_mem[cpu_addr] <= cpu_din;
  end

  assign cpu_hold  = (state_q == COMMIT);
  assign load_ok   = load_ok_q;
  assign load_err  = load_err_q;
  assign ioctl_din = din_q;
  assign cpu_dout  = cpu_dout_q;

endmodule

// File: tb/tb_hsram_io.sv
// Directed self-checking bench for hsram_io: load, verify, commit, upload, reset abort.
module tb_hsram_io;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic [7:0]  ioctl_din;
  logic [5:0]  cpu_addr = 6'd0;
  logic [7:0]  cpu_din = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_dout;
  logic        cpu_hold, load_ok, load_err;

  int checks = 0;
  int failures = 0;

`ifdef HSRAM_CHECKSUM_EN
  localparam logic [7:0] ExpUpChk   = 8'hE0;
  localparam int         BadCycles  = 65;
  localparam logic       BadOk      = 1'b0;
  localparam logic       BadErr     = 1'b1;
`else
  localparam logic [7:0] ExpUpChk   = 8'h00;
  localparam int         BadCycles  = 129;
  localparam logic       BadOk      = 1'b1;
  localparam logic       BadErr     = 1'b0;
`endif

  hsram_io #(.INDEX(8'hFF)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr),
    .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_din(ioctl_din),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
    .cpu_hold(cpu_hold), .load_ok(load_ok), .load_err(load_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic cpuWrite(input logic [5:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic cpuRead(input logic [5:0] a, output logic [7:0] d);
    cpu_addr = a; cpu_we = 1'b0;
    tick();
    d = cpu_dout;
  endtask

  // One host byte write on the data_io bus.
  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Image bytes 0x01..0x40 at 0..63, checksum byte at 64; download is dropped on return.
  task automatic downloadImage(input logic [7:0] idx, input logic [7:0] chk);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
    for (int n = 0; n < 64; n++) applyStimulus(25'(n), 8'(n + 1));
    applyStimulus(25'd64, chk);
    ioctl_download = 1'b0;
  endtask

  task automatic waitPulse(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!load_ok && !load_err && cycles < 400);
  endtask

  initial begin
    logic [7:0] rd;
    logic       anyHigh;
    int         cyc;

    $display("[TB] starting hsram_io bench");
    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("rstCpuDout", cpu_dout, 0);
    checkOutput("rstIoctlDin", ioctl_din, 0);
    checkOutput("rstCpuHold", cpu_hold, 0);
    checkOutput("rstLoadOk", load_ok, 0);
    checkOutput("rstLoadErr", load_err, 0);
    reset_n = 1'b1;
    repeat (4) tick();

    for (int n = 0; n < 64; n++) cpuWrite(6'(n), 8'(n + 8'h80));
    cpuRead(6'd7, rd);
    checkOutput("cpuReadback7", rd, 8'h87);
    cpuRead(6'd63, rd);
    checkOutput("cpuReadback63", rd, 8'hBF);

    // Foreign index: session must be ignored entirely.
    downloadImage(8'h00, 8'hE0);
    anyHigh = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      anyHigh = anyHigh | cpu_hold | load_ok | load_err;
    end
    checkOutput("wrongIdxNoActivity", anyHigh, 0);
    cpuRead(6'd0, rd);
    checkOutput("wrongIdxMainKept", rd, 8'h80);

    // Good image, reset asserted at commit cycle 10.
    cpu_addr = 6'd3;
    downloadImage(8'hFF, 8'hE0);
    repeat (65) tick();
    checkOutput("commitHoldHigh", cpu_hold, 1);
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    checkOutput("abortCpuHold", cpu_hold, 0);
    checkOutput("abortCpuDout", cpu_dout, 0);
    checkOutput("abortLoadOk", load_ok, 0);
    checkOutput("abortLoadErr", load_err, 0);
    checkOutput("abortIoctlDin", ioctl_din, 0);
    #20;
    reset_n = 1'b1;
    repeat (4) tick();
    for (int n = 0; n < 64; n++) begin
      cpuRead(6'(n), rd);
      checkOutput($sformatf("abortMain[%0d]", n), rd, (n < 10) ? 8'(n + 1) : 8'(n + 8'h80));
    end

    // Full good load with a CPU write to address 5 late in the commit.
    downloadImage(8'hFF, 8'hE0);
    repeat (65) tick();
    checkOutput("commitHoldHigh2", cpu_hold, 1);
    repeat (20) tick();
    cpuWrite(6'd5, 8'h55);
    checkOutput("commitHoldMid", cpu_hold, 1);
    waitPulse(cyc);
    checkOutput("goodOkLatency", cyc, 43);
    checkOutput("goodLoadOk", load_ok, 1);
    checkOutput("goodLoadErr", load_err, 0);
    tick();
    checkOutput("goodOkPulseWidth", load_ok, 0);
    checkOutput("goodHoldReleased", cpu_hold, 0);
    for (int n = 0; n < 64; n++) begin
      cpuRead(6'(n), rd);
      checkOutput($sformatf("goodMain[%0d]", n), rd, 8'(n + 1));
    end

    // Upload: one-cycle latency per address, checksum at 64, zero beyond.
    ioctl_index = 8'hFF;
    ioctl_addr = '0;
    ioctl_upload = 1'b1;
    tick();
    for (int a = 0; a < 66; a++) begin
      ioctl_addr = 25'(a);
      tick();
      checkOutput($sformatf("upload[%0d]", a), ioctl_din,
                  (a < 64) ? 8'(a + 1) : ((a == 64) ? ExpUpChk : 8'h00));
    end
    applyStimulus(25'd3, 8'hAA);
    cpuWrite(6'd5, 8'h55);
    ioctl_upload = 1'b0;
    repeat (2) tick();
    cpuRead(6'd5, rd);
    checkOutput("uploadCpuWrite5", rd, 8'h55);
    checkOutput("uploadEndDin", ioctl_din, 0);

    // Same image with a zero checksum byte.
    downloadImage(8'hFF, 8'h00);
    waitPulse(cyc);
    checkOutput("badCycles", cyc, BadCycles);
    checkOutput("badLoadOk", load_ok, BadOk);
    checkOutput("badLoadErr", load_err, BadErr);
    tick();
    checkOutput("badPulseWidthOk", load_ok, 0);
    checkOutput("badPulseWidthErr", load_err, 0);
    cpuRead(6'd5, rd);
    checkOutput("badMain5", rd, BadErr ? 8'h55 : 8'h06);
    cpuRead(6'd3, rd);
    checkOutput("badMain3", rd, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hsram_io.md
HSRAM_IO -- requirements
Module: hsram_io

Interface
REQ-001 SHALL have parameter INDEX, default 8'hFF, the ioctl_index value that selects the high-score image.
REQ-002 SHALL have port clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports ioctl_download, ioctl_upload, ioctl_wr  in  1 each  data_io session/strobe signals.
REQ-005 SHALL have ports ioctl_index  in  8,  ioctl_addr  in  25,  ioctl_dout  in  8  (host-to-core byte).
REQ-006 SHALL have port ioctl_din  out  8  core-to-host byte during upload.
REQ-007 SHALL have ports cpu_addr  in  6,  cpu_din  in  8,  cpu_we  in  1,  cpu_dout  out  8  for game-side access to the 64x8 main RAM.
REQ-008 SHALL have ports cpu_hold  out  1,  load_ok  out  1,  load_err  out  1.

Function
REQ-009 SHALL contain a 64x8 main RAM and a 64x8 shadow RAM.
REQ-010 cpu_dout SHALL be main[cpu_addr] registered with 1-cycle latency; cpu_we writes main[cpu_addr] in the same cycle unless cpu_hold is high, in which case the write is dropped.
REQ-011 SHALL latch sel = (ioctl_index == INDEX) on each rising edge of ioctl_download or ioctl_upload; sel gates the whole session.
REQ-012 States: IDLE, LOAD, VERIFY, COMMIT, UPLOAD.
REQ-013 IDLE -> LOAD on download rising edge with sel; IDLE -> UPLOAD on upload rising edge with sel; sessions without sel are ignored.
REQ-014 LOAD: ioctl_wr with ioctl_addr < 64 writes shadow[addr[5:0]]; addr == 64 stores the checksum byte; addr > 64 is ignored.
REQ-015 LOAD -> VERIFY on falling edge of ioctl_download.
REQ-016 VERIFY SHALL take exactly 64 cycles, summing the shadow mod 256 plus the checksum byte; pass = (result == 8'h00); then go to COMMIT on pass, or pulse load_err for 1 cycle and go to IDLE on fail, leaving main untouched.
REQ-017 COMMIT SHALL copy shadow to main at one byte per cycle for addresses 0..63 (64 cycles), hold cpu_hold high throughout, then pulse load_ok for 1 cycle and go to IDLE.
REQ-018 UPLOAD: ioctl_din SHALL be main[ioctl_addr[5:0]] registered with 1-cycle latency for addresses 0..63, the checksum for address 64, and 8'h00 for addresses above 64.
REQ-019 Upload checksum SHALL be the two's complement of the mod-256 sum of bytes served, accumulated once per distinct address 0..63; the accumulator is cleared on upload entry.
REQ-020 UPLOAD -> IDLE on falling edge of ioctl_upload; ioctl_wr during UPLOAD SHALL be ignored.
REQ-021 CPU writes during LOAD, VERIFY and UPLOAD SHALL proceed normally (no snapshot).
REQ-022 A download rising edge while the block is not in IDLE SHALL be ignored.

Reset
REQ-023 While reset_n is low: state IDLE; cpu_hold, load_ok, load_err, ioctl_din, cpu_dout = 0; checksum and accumulators = 0.
REQ-024 RAM contents SHALL NOT be reset; a reset during COMMIT SHALL abort the copy, leaving main partially updated.
REQ-025 reset_n SHALL assert asynchronously and release synchronously through a 2-flop synchroniser.

Configuration
REQ-026 With HSRAM_CHECKSUM_EN defined, checksum handling SHALL be as in REQ-014, REQ-016, REQ-018 and REQ-019.
REQ-027 Without HSRAM_CHECKSUM_EN: address 64 is ignored on load and reads 8'h00 on upload; VERIFY always passes and still takes 64 cycles; the accumulator logic is absent.

Verification
REQ-028 Download bytes 0x01..0x40 plus checksum 0xE0 (sum 0x820, so 0x20 + 0xE0 = 0x00), then drop ioctl_download -> after 64 VERIFY + 64 COMMIT cycles, load_ok pulses and main[n] = n+1.
REQ-029 Same image with checksum 0x00 (macro on) -> load_err pulses and main is unchanged; with the macro off -> load_ok pulses.
REQ-030 Upload addresses 0..64 after REQ-028 -> ioctl_din returns 0x01..0x40 and then 0xE0, each one cycle after the address is presented.
REQ-031 Download with ioctl_index = 0 -> no state change, no pulses, and cpu_hold stays 0.
REQ-032 cpu_we to address 5 during COMMIT -> write dropped and main[5] equals the shadow value; the same write during UPLOAD -> main[5] updated.
REQ-033 Assert reset_n low at COMMIT cycle 10 -> all outputs 0 immediately, state IDLE, main[0..9] new, main[10..63] old.
